approx_mul_err_accum: RTL and testbench
=======================================

Name: approx_mul_err_accum

Overview:
- Sits directly downstream of an unsigned 8x8 approximate multiplier.
- Consumes each operand pair (x, y) and the product z_approx that the multiplier produced for it, and computes the exact product internally.
- Accumulates error statistics over a programmed number of samples: sum of squared error, maximum absolute error, and a nonzero-error count.
- Used in hardware characterisation runs to measure the L2 cost of a multiplier variant.

Parameters:
- ACC_W, 48, width of the squared-error accumulator (at least 32).
- CNT_W, 17, width of the sample-count configuration and counters.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- start  input  1  one-cycle pulse; honoured only in IDLE or DONE
- cfg_count  input  CNT_W  number of samples to accept; latched on start
- in_valid  input  1  sample valid
- in_ready  output  1  block accepts a sample this cycle
- x  input  8  multiplicand
- y  input  8  multiplier
- z_approx  input  16  approximate product for (x, y)
- busy  output  1  high in RUN and DRAIN
- done  output  1  high in DONE
- sse  output  ACC_W  sum of squared errors
- max_abs_err  output  16  largest abs(x*y - z_approx) seen
- err_cnt  output  CNT_W  samples with nonzero error
- sat  output  1  sticky: sse saturated
- err_sum  output  ACC_W  signed error sum (see Optional Feature)

Behaviour:
- Reset: rst sampled on the clk edge. Every output goes to 0, state goes to IDLE, and pipeline valids are cleared. Reset mid-run discards all in-flight samples.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: when the accepted count reaches the latched cfg_count -> DRAIN.
  - DRAIN: when the pipeline is empty -> DONE.
  - DONE: start -> RUN.
- On start:
  - Latch cfg_count.
  - Clear sse, max_abs_err, err_cnt, sat and err_sum in the same cycle.
  - start=1 in RUN or DRAIN is ignored.
- cfg_count=0: start goes RUN -> DRAIN -> DONE, each state lasting one cycle, with no sample accepted and all results 0.
- Handshake:
  - in_ready = (state==RUN) && (accepted < cfg_latched).
  - A sample is accepted when in_valid && in_ready. There is no backpressure inside the pipeline.
  - in_ready drops in the cycle after the last acceptance.
- Pipeline, 3 stages:
  - S1: exact = x*y (16 b unsigned); e = exact - z_approx as 17-bit signed; a = abs(e).
  - S2: sq = a*a (32 b unsigned, max 65535^2 fits).
  - S3: accumulate.
- Latency: an accepted sample is reflected in the outputs on the 3rd rising edge after acceptance. DRAIN lasts until the S3 valid of the last sample has been consumed.
- Accumulation in S3:
  - sse += zero-extended sq. On carry out of ACC_W, sse holds all-ones and sat is set (sticky until start or rst).
  - max_abs_err = max(max_abs_err, a[15:0]). Case a=65536 is not reachable; a is at most 65535.
  - err_cnt += (e != 0).
- Outputs are registered and stable in DONE until the next start.
- z_approx > exact (negative e) is legal; abs is taken before squaring.
- Back-to-back acceptance every cycle is required; throughput is 1 sample/clk.

Optional Feature:
- Macro APPROX_ERR_BIAS_EN.
- Defined: S3 also accumulates err_sum += sign-extended e (two's complement, ACC_W bits, wraps, no saturation). err_sum is cleared on start and rst.
- Undefined: err_sum is tied to 0 and no bias adder is synthesised. All other behaviour is identical.

Test Plan:
- rst during RUN after 2 accepted samples -> next cycle: state IDLE, in_ready=0, sse=0, err_cnt=0, done=0. A later start with cfg_count=1 works normally.
- start, cfg_count=2; samples (x=0xFF, y=0xFF, z_approx=64772) and (x=3, y=3, z_approx=0) on consecutive cycles -> done; sse=64009+81=64090, max_abs_err=253, err_cnt=2; with APPROX_ERR_BIAS_EN, err_sum=262.
- cfg_count=3, all samples z_approx=exact (e.g. x=10, y=20, z=200) -> sse=0, max_abs_err=0, err_cnt=0. in_ready falls after exactly 3 acceptances, and a 4th valid sample is not accepted.
- Negative error: x=2, y=2, z_approx=0x0010 -> e=-12, sse=144, max_abs_err=12; with APPROX_ERR_BIAS_EN, err_sum=all-ones-minus-11 (i.e. -12).
- ACC_W=32, repeated x=0, y=0, z_approx=0xFFFF with cfg_count=2 -> second sample overflows: sse=0xFFFFFFFF, sat=1. sat stays 1 through DONE and clears on the next start.
- cfg_count=0 start -> done asserted 3 cycles later with no in_ready pulse. A start pulse during DRAIN of a normal run is ignored: results are unchanged.

Source files
------------

// File: rtl/approx_mul_err_accum.sv
// Error-statistics accumulator for an unsigned 8x8 approximate multiplier.
// Optional signed bias sum enabled by defining APPROX_ERR_BIAS_EN.
module approx_mul_err_accum #(
    parameter int unsigned ACC_W = 48,
    parameter int unsigned CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       x,
    input  logic [7:0]       y,
    input  logic [15:0]      z_approx,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sse,
    output logic [15:0]      max_abs_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             sat,
    output logic [ACC_W-1:0] err_sum
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cfg_q;
    logic [CNT_W-1:0] acc_cnt_q;
    logic [CNT_W-1:0] acc_cnt_d;
    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             accept_c;
    logic             start_c;

    logic [15:0]      exact_c;
    logic [16:0]      e_c;
    logic [15:0]      a_c;

    logic             s1_v_q;
    logic [15:0]      s1_a_q;
    logic             s1_nz_q;
    logic             s2_v_q;
    logic [31:0]      s2_sq_q;
    logic [15:0]      s2_a_q;
    logic             s2_nz_q;

    logic [ACC_W-1:0] sse_q;
    logic [15:0]      max_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic             sat_q;
    logic [SUM_W-1:0] sse_sum_c;

    // S1 arithmetic, handshake qualifiers and the saturating SSE adder
    always_comb begin
        exact_c   = 16'(x) * 16'(y);
        e_c       = {1'b0, exact_c} - {1'b0, z_approx};
        a_c       = e_c[16] ? 16'(17'd0 - e_c) : e_c[15:0];
        accept_c  = in_valid && in_ready_q;
        start_c   = start && ((state_q == IDLE) || (state_q == DONE));
        acc_cnt_d = acc_cnt_q + CNT_W'(accept_c);
        sse_sum_c = {1'b0, sse_q} + SUM_W'(s2_sq_q);
    end

    // Control FSM; DONE is entered on the edge that absorbs the last S3 sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            acc_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= RUN;
                        cfg_q      <= cfg_count;
                        acc_cnt_q  <= '0;
                        in_ready_q <= (cfg_count != '0);
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                RUN: begin
                    acc_cnt_q <= acc_cnt_d;
                    if (acc_cnt_d == cfg_q) begin
                        state_q    <= DRAIN;
                        in_ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!s1_v_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
        end else begin
            s1_v_q <= accept_c;
            s2_v_q <= s1_v_q;
        end
    end

    always_ff @(posedge clk) begin
        s1_a_q  <= a_c;
        s1_nz_q <= (e_c != '0);
        s2_sq_q <= 32'(s1_a_q) * 32'(s1_a_q);
        s2_a_q  <= s1_a_q;
        s2_nz_q <= s1_nz_q;
    end

    // S3: statistics, cleared by an honoured start
    always_ff @(posedge clk) begin
        if (rst || start_c) begin
            sse_q     <= '0;
            max_q     <= '0;
            err_cnt_q <= '0;
            sat_q     <= 1'b0;
        end else if (s2_v_q) begin
            sse_q     <= sse_sum_c[ACC_W] ? '1 : sse_sum_c[ACC_W-1:0];
            sat_q     <= sat_q | sse_sum_c[ACC_W];
            if (s2_a_q > max_q) begin
                max_q <= s2_a_q;
            end
            err_cnt_q <= err_cnt_q + CNT_W'(s2_nz_q);
        end
    end

`ifdef APPROX_ERR_BIAS_EN
    logic [16:0]      s1_e_q;
    logic [16:0]      s2_e_q;
    logic [ACC_W-1:0] err_sum_q;

    always_ff @(posedge clk) begin
        s1_e_q <= e_c;
        s2_e_q <= s1_e_q;
    end

    // Signed bias sum wraps modulo 2^ACC_W
    always_ff @(posedge clk) begin
        if (rst || start_c) begin
            err_sum_q <= '0;
        end else if (s2_v_q) begin
            err_sum_q <= err_sum_q + ACC_W'($signed(s2_e_q));
        end
    end

    assign err_sum = err_sum_q;
`else
    assign err_sum = '0;
`endif

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sse         = sse_q;
    assign max_abs_err = max_q;
    assign err_cnt     = err_cnt_q;
    assign sat         = sat_q;

endmodule

// File: tb/tb_approx_mul_err_accum.sv
// Randomised bench for approx_mul_err_accum against a plain-arithmetic error model.
module tb_approx_mul_err_accum;

    localparam int unsigned ACC_W = 32;
    localparam int unsigned CNT_W = 17;
    localparam logic [63:0] SSE_MAX = (64'd1 << ACC_W) - 64'd1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] cfg_count;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       x;
    logic [7:0]       y;
    logic [15:0]      z_approx;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] sse;
    logic [15:0]      max_abs_err;
    logic [CNT_W-1:0] err_cnt;
    logic             sat;
    logic [ACC_W-1:0] err_sum;

    approx_mul_err_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_count(cfg_count),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
        .z_approx(z_approx), .busy(busy), .done(done), .sse(sse),
        .max_abs_err(max_abs_err), .err_cnt(err_cnt), .sat(sat),
        .err_sum(err_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] m_sse;
    logic [63:0] m_bias;
    int          m_max;
    int          m_cnt;
    bit          m_sat;

    logic [7:0]  qx[$];
    logic [7:0]  qy[$];
    logic [15:0] qz[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_sse  = '0;
        m_bias = '0;
        m_max  = 0;
        m_cnt  = 0;
        m_sat  = 1'b0;
    endtask

    task automatic model_add(input logic [7:0] xx, input logic [7:0] yy, input logic [15:0] zz);
        int          ex;
        int          e;
        int          a;
        logic [63:0] s;
        ex = int'(xx) * int'(yy);
        e  = ex - int'(zz);
        a  = (e < 0) ? -e : e;
        s  = m_sse + 64'(longint'(a) * longint'(a));
        if (s > SSE_MAX) begin
            m_sse = SSE_MAX;
            m_sat = 1'b1;
        end else begin
            m_sse = s;
        end
        if (a > m_max) m_max = a;
        if (e != 0) m_cnt++;
        m_bias = m_bias + 64'(longint'(e));
    endtask

    task automatic push(input logic [7:0] xx, input logic [7:0] yy, input logic [15:0] zz);
        qx.push_back(xx);
        qy.push_back(yy);
        qz.push_back(zz);
    endtask

    task automatic gen_random(input int n);
        logic [7:0]  xx;
        logic [7:0]  yy;
        logic [15:0] ex;
        for (int i = 0; i < n; i++) begin
            xx = 8'($urandom);
            yy = 8'($urandom);
            ex = 16'(xx) * 16'(yy);
            case ($urandom_range(0, 3))
                0: push(xx, yy, ex);
                1: push(xx, yy, ex + 16'($urandom_range(0, 40)));
                2: push(xx, yy, ex - 16'($urandom_range(0, 40)));
                default: push(xx, yy, 16'($urandom));
            endcase
        end
    endtask

    task automatic check_results(input string tag);
        logic [63:0] exp_bias;
`ifdef APPROX_ERR_BIAS_EN
        exp_bias = m_bias & SSE_MAX;
`else
        exp_bias = '0;
`endif
        check({tag, "_sse"},     64'(sse),         m_sse);
        check({tag, "_max"},     64'(max_abs_err), 64'(m_max));
        check({tag, "_err_cnt"}, 64'(err_cnt),     64'(m_cnt));
        check({tag, "_sat"},     64'(sat),         64'(m_sat));
        check({tag, "_err_sum"}, 64'(err_sum),     exp_bias);
    endtask

    // One complete job: start, feed cfg samples from the queues, offer one surplus, wait for done
    task automatic run_job(input string tag, input int cfg, input bit gaps, input bit poke_drain);
        int acc;
        int cyc;
        model_clear();
        start     = 1'b1;
        cfg_count = CNT_W'(cfg);
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        acc = 0;
        cyc = 0;
        while (acc < cfg && cyc < 400) begin
            check({tag, "_in_ready_hi"}, 64'(in_ready), 64'd1);
            if (qx.size() == 0) gen_random(1);
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            x        = qx[0];
            y        = qy[0];
            z_approx = qz[0];
            tick();
            if (in_valid) begin
                model_add(qx[0], qy[0], qz[0]);
                void'(qx.pop_front());
                void'(qy.pop_front());
                void'(qz.pop_front());
                acc++;
            end
            cyc++;
        end
        if (acc < cfg) check({tag, "_accept_timeout"}, 64'(acc), 64'(cfg));
        in_valid = 1'b1;
        x        = 8'($urandom);
        y        = 8'($urandom);
        z_approx = 16'($urandom);
        check({tag, "_in_ready_lo"}, 64'(in_ready), 64'd0);
        if (poke_drain) begin
            start     = 1'b1;
            cfg_count = CNT_W'(7);
        end
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_lo"}, 64'(busy), 64'd0);
        check_results(tag);
        tick();
        tick();
        check({tag, "_hold_done"}, 64'(done), 64'd1);
        check({tag, "_hold_sse"}, 64'(sse), m_sse);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cfg_count = '0;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        z_approx  = '0;
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        model_clear();
        check_results("rst");
        rst = 1'b0;
        tick();

        // Two-sample directed job
        push(8'hFF, 8'hFF, 16'd64772);
        push(8'd3, 8'd3, 16'd0);
        run_job("pair", 2, 1'b0, 1'b0);
        check("pair_sse_lit", 64'(sse), 64'd64090);
        check("pair_max_lit", 64'(max_abs_err), 64'd253);
        check("pair_cnt_lit", 64'(err_cnt), 64'd2);
`ifdef APPROX_ERR_BIAS_EN
        check("pair_bias_lit", 64'(err_sum), 64'd262);
`endif

        // Exact products only; a fourth valid sample must be refused
        for (int i = 0; i < 3; i++) push(8'd10, 8'd20, 16'd200);
        run_job("exact", 3, 1'b0, 1'b0);
        check("exact_sse_lit", 64'(sse), 64'd0);

        // Negative error
        push(8'd2, 8'd2, 16'h0010);
        run_job("neg", 1, 1'b0, 1'b0);
        check("neg_sse_lit", 64'(sse), 64'd144);
        check("neg_max_lit", 64'(max_abs_err), 64'd12);
`ifdef APPROX_ERR_BIAS_EN
        check("neg_bias_lit", 64'(err_sum), 64'hFFFF_FFF4);
`endif

        // Saturation of the 32-bit accumulator
        push(8'd0, 8'd0, 16'hFFFF);
        push(8'd0, 8'd0, 16'hFFFF);
        run_job("sat", 2, 1'b0, 1'b0);
        check("sat_sse_lit", 64'(sse), 64'hFFFF_FFFF);
        check("sat_flag_lit", 64'(sat), 64'd1);

        // Zero-length job: RUN, DRAIN, DONE one cycle each, no in_ready
        start     = 1'b1;
        cfg_count = '0;
        tick();
        start = 1'b0;
        check("zero_sat_cleared", 64'(sat), 64'd0);
        check("zero_sse_cleared", 64'(sse), 64'd0);
        check("zero_rdy_c1", 64'(in_ready), 64'd0);
        check("zero_done_c1", 64'(done), 64'd0);
        tick();
        check("zero_rdy_c2", 64'(in_ready), 64'd0);
        check("zero_busy_c2", 64'(busy), 64'd1);
        check("zero_done_c2", 64'(done), 64'd0);
        tick();
        check("zero_rdy_c3", 64'(in_ready), 64'd0);
        check("zero_done_c3", 64'(done), 64'd1);
        check("zero_cnt", 64'(err_cnt), 64'd0);

        // Start pulse during DRAIN is ignored
        gen_random(6);
        run_job("poke", 6, 1'b1, 1'b1);

        // Reset after two acceptances discards the in-flight samples
        gen_random(2);
        start     = 1'b1;
        cfg_count = CNT_W'(5);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            x        = qx.pop_front();
            y        = qy.pop_front();
            z_approx = qz.pop_front();
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_in_ready", 64'(in_ready), 64'd0);
        check("mrst_sse", 64'(sse), 64'd0);
        check("mrst_cnt", 64'(err_cnt), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        tick();
        tick();
        check("mrst_sse_late", 64'(sse), 64'd0);
        gen_random(1);
        run_job("post_rst", 1, 1'b0, 1'b0);

        // Randomised jobs
        for (int j = 0; j < 10; j++) begin
            int n;
            n = $urandom_range(1, 24);
            gen_random(n);
            run_job($sformatf("rand%0d", j), n, 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
